// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for one single-port memory with a one-cycle read latency.
// Optional saturating statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   input  logic              we0,
   input  logic              we1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [31:0]       rdata0,
   output logic [31:0]       rdata1,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data_out,
   output logic              mem_we,
   input  logic [31:0]       mem_data_in
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_gnt0,
   output logic [15:0]       stat_gnt1,
   output logic [15:0]       stat_conflict
`endif
);

   logic grant0_s;
   logic grant1_s;
   logic last_gnt_q;
   logic last_gnt_d;
   logic pend_valid_q;
   logic pend_valid_d;
   logic pend_id_q;
   logic pend_id_d;

   // Grant decision: single requester wins outright, a contest goes to the one not granted last.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (!resetn) begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end else if (req0 && req1) begin
         if (last_gnt_q) begin
            grant0_s = 1'b1;
         end else begin
            grant1_s = 1'b1;
         end
      end else begin
         grant0_s = req0;
         grant1_s = req1;
      end
   end

   assign gnt0 = grant0_s;
   assign gnt1 = grant1_s;

   // Shared memory port mux; an idle cycle parks the bus at zero.
   always_comb begin
      mem_address  = {ADDR_W{1'b0}};
      mem_data_out = 32'd0;
      mem_we       = 1'b0;
      case ({grant1_s, grant0_s})
         2'b01: begin
            mem_address  = addr0;
            mem_data_out = wdata0;
            mem_we       = we0;
         end
         2'b10: begin
            mem_address  = addr1;
            mem_data_out = wdata1;
            mem_we       = we1;
         end
         default: begin
            mem_address  = {ADDR_W{1'b0}};
            mem_data_out = 32'd0;
            mem_we       = 1'b0;
         end
      endcase
   end

   // Next-state for the round-robin pointer and the pending-read tag.
   always_comb begin
      last_gnt_d   = last_gnt_q;
      pend_valid_d = 1'b0;
      pend_id_d    = pend_id_q;
      if (grant0_s) begin
         last_gnt_d   = 1'b0;
         pend_valid_d = ~we0;
         pend_id_d    = 1'b0;
      end else if (grant1_s) begin
         last_gnt_d   = 1'b1;
         pend_valid_d = ~we1;
         pend_id_d    = 1'b1;
      end else begin
         last_gnt_d   = last_gnt_q;
         pend_valid_d = 1'b0;
         pend_id_d    = pend_id_q;
      end
   end

   // Pointer resets to 1 so requester 0 wins the first contested cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_gnt_q   <= 1'b1;
         pend_valid_q <= 1'b0;
         pend_id_q    <= 1'b0;
      end else begin
         last_gnt_q   <= last_gnt_d;
         pend_valid_q <= pend_valid_d;
         pend_id_q    <= pend_id_d;
      end
   end

   // Read data is steered by the registered tag, so it stays correct while the next grant is issued.
   assign rvalid0 = pend_valid_q & ~pend_id_q;
   assign rvalid1 = pend_valid_q & pend_id_q;
   assign rdata0  = rvalid0 ? mem_data_in : 32'd0;
   assign rdata1  = rvalid1 ? mem_data_in : 32'd0;

`ifdef MEM_ARB_STATS_EN
   logic [15:0] stat_gnt0_q;
   logic [15:0] stat_gnt0_d;
   logic [15:0] stat_gnt1_q;
   logic [15:0] stat_gnt1_d;
   logic [15:0] stat_conflict_q;
   logic [15:0] stat_conflict_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
      logic [15:0] res;
      if (en && (val != 16'hFFFF)) begin
         res = val + 16'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

   // Saturating event counters.
   always_comb begin
      stat_gnt0_d     = sat_inc(stat_gnt0_q, grant0_s);
      stat_gnt1_d     = sat_inc(stat_gnt1_q, grant1_s);
      stat_conflict_d = sat_inc(stat_conflict_q, req0 & req1);
   end

   // Counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_gnt0_q     <= 16'd0;
         stat_gnt1_q     <= 16'd0;
         stat_conflict_q <= 16'd0;
      end else begin
         stat_gnt0_q     <= stat_gnt0_d;
         stat_gnt1_q     <= stat_gnt1_d;
         stat_conflict_q <= stat_conflict_d;
      end
   end

   assign stat_gnt0     = stat_gnt0_q;
   assign stat_gnt1     = stat_gnt1_q;
   assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cycles push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_arbiter;

   typedef struct packed {
      logic        in_rst;
      logic        g0;
      logic        g1;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rv0;
      logic        rv1;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_address, mem_data_out, mem_data_in;
   logic        mem_we;
`ifdef MEM_ARB_STATS_EN
   logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req0         (req0),
      .req1         (req1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .we0          (we0),
      .we1          (we1),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .rvalid0      (rvalid0),
      .rvalid1      (rvalid1),
      .rdata0       (rdata0),
      .rdata1       (rdata1),
      .mem_address  (mem_address),
      .mem_data_out (mem_data_out),
      .mem_we       (mem_we),
      .mem_data_in  (mem_data_in)
`ifdef MEM_ARB_STATS_EN
      ,
      .stat_gnt0    (stat_gnt0),
      .stat_gnt1    (stat_gnt1),
      .stat_conflict(stat_conflict)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // One clock cycle of stimulus plus its expected response.
   task automatic cyc(input logic rn, input logic r0, input logic r1, input logic w0, input logic w1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] min,
                      input logic eg0, input logic eg1, input logic erv0, input logic erv1,
                      input logic [31:0] erd);
      exp_t e;
      @(posedge clk);
      #1;
      resetn = rn; req0 = r0; req1 = r1; we0 = w0; we1 = w1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; mem_data_in = min;
      e.in_rst = ~rn;
      e.g0 = eg0; e.g1 = eg1;
      e.we    = eg0 ? w0 : (eg1 ? w1 : 1'b0);
      e.addr  = eg0 ? a0 : (eg1 ? a1 : 32'd0);
      e.wdata = eg0 ? d0 : (eg1 ? d1 : 32'd0);
      e.rv0 = erv0; e.rv1 = erv1; e.rdata = erd;
      sb.push_back(e);
   endtask

   // Monitor: compare every presented cycle against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, e.g1, e.g0});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            chk("mem_address", mem_address, e.addr);
            chk("mem_data_out", mem_data_out, e.wdata);
            chk("rvalid", {30'd0, rvalid1, rvalid0}, {30'd0, e.rv1, e.rv0});
            if (e.rv0 || e.in_rst) chk("rdata0", rdata0, e.rv0 ? e.rdata : 32'd0);
            if (e.rv1 || e.in_rst) chk("rdata1", rdata1, e.rv1 ? e.rdata : 32'd0);
         end
      end
   end

   initial begin
      resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0; mem_data_in = 32'd0;
      // reset with both requests pending: everything quiet
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'd0, 32'd0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'd0, 32'd0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      // single read on requester 0
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
      // write on requester 1; requester 0 signals are garbage with req0 low
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hBAD, 32'h40, 32'hFFFF0000, 32'h12345678, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h999, 32'h888, 32'd1, 32'd2, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      // read on 0 makes 0 the last granted, then 3 idle cycles, then a contest goes to 1
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h11110000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11110000);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0BAD0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0BAD0002, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 32'd0, 32'd0, 32'h22220000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22220000);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h33330000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33330000);
      // read grant, then reset asserted the next cycle: no rvalid, all outputs zero
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h301, 32'd7, 32'd8, 32'h44440000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h301, 32'd7, 32'd8, 32'h44440000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      // both held after release: grants 0,1,0,1 with alternating rvalids one cycle later
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h600, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h600, 32'd0, 32'd0, 32'hC0DE0001, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC0DE0001);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h600, 32'd0, 32'd0, 32'hC0DE0002, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC0DE0002);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h600, 32'd0, 32'd0, 32'hC0DE0003, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC0DE0003);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hC0DE0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0DE0004);
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);

`ifdef MEM_ARB_STATS_EN
      @(posedge clk); #1;
      resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk("stat_conflict_rst", {16'd0, stat_conflict}, 32'd0);
      chk("stat_gnt0_rst", {16'd0, stat_gnt0}, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
      repeat (65538) @(posedge clk);
      #1;
      chk("stat_conflict_sat", {16'd0, stat_conflict}, 32'h0000FFFF);
      chk("stat_gnt0", {16'd0, stat_gnt0}, 32'd32769);
      chk("stat_gnt1", {16'd0, stat_gnt1}, 32'd32769);
      req0 = 1'b0; req1 = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  input  1  per-requester access request, held high until granted.
REQ-005 SHALL have ports addr0/addr1  input  ADDR_W  per-requester address.
REQ-006 SHALL have ports wdata0/wdata1  input  32  per-requester write data.
REQ-007 SHALL have ports we0/we1  input  1  per-requester write enable (1 = write, 0 = read).
REQ-008 SHALL have ports gnt0/gnt1  output  1  combinational grant; request accepted this cycle.
REQ-009 SHALL have ports rvalid0/rvalid1  output  1  registered read-data-valid pulse.
REQ-010 SHALL have ports rdata0/rdata1  output  32  read data, meaningful only while the matching rvalid is high.
REQ-011 SHALL have port mem_address  output  ADDR_W  shared memory address.
REQ-012 SHALL have port mem_data_out  output  32  shared memory write data.
REQ-013 SHALL have port mem_we  output  1  shared memory write enable.
REQ-014 SHALL have port mem_data_in  input  32  memory read data, valid one cycle after the address is presented.

Function
REQ-015 SHALL assert at most one of gnt0/gnt1 in any cycle.
REQ-016 SHALL grant the only requester when exactly one req is high.
REQ-017 SHALL, when both req are high, grant the requester not granted most recently (round-robin via a 1-bit last_gnt register).
REQ-018 SHALL update last_gnt only on a cycle in which a grant is issued; idle cycles leave it unchanged.
REQ-019 SHALL drive mem_address/mem_data_out/mem_we from the granted requester in the grant cycle; with no grant, mem_we = 0 and mem_address/mem_data_out = 0.
REQ-020 SHALL, for a granted read, assert the matching rvalid exactly one cycle after gnt, with rdata = mem_data_in of that cycle.
REQ-021 SHALL never assert rvalid for a granted write.
REQ-022 SHALL support back-to-back grants every cycle, including read-to-read across requesters, with no bubble cycle.
REQ-023 SHALL route rdata by a registered pending-read tag (valid bit + requester id), not by the current grant.
REQ-024 SHALL give a requester holding req continuously a grant within 2 cycles (no starvation).
REQ-025 SHALL ignore addrN/wdataN/weN while reqN is low.

Reset
REQ-026 SHALL, while resetn = 0, force gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, mem_we = 0, and hold last_gnt = 1 (so requester 0 wins the first contested cycle).
REQ-027 SHALL clear the pending-read tag on reset; a read granted in the cycle before reset assertion produces no rvalid.
REQ-028 SHALL drive rdata0/rdata1 = 0 while reset is asserted.

Configuration
REQ-029 SHALL, when MEM_ARB_STATS_EN is defined, add outputs stat_gnt0 and stat_gnt1 (16 bits each, saturating grant counters) and stat_conflict (16 bits, saturating count of cycles with both req high); all reset to 0.
REQ-030 SHALL, when MEM_ARB_STATS_EN is undefined, omit these ports and counters, with arbitration behaviour otherwise identical.

Verification
REQ-031 SHALL cover: req0=1, we0=0, addr0=0x100, memory returns 0xDEADBEEF -> gnt0=1 in cycle 0, rvalid0=1 with rdata0=0xDEADBEEF in cycle 1, rvalid1=0.
REQ-032 SHALL cover: both req held high for 4 cycles after reset -> grants 0,1,0,1; both rvalids pulse in alternation, one cycle after each grant.
REQ-033 SHALL cover: req1=1, we1=1, addr1=0x40, wdata1=0x12345678 -> mem_we=1, mem_address=0x40, mem_data_out=0x12345678 for one cycle, no rvalid.
REQ-034 SHALL cover: resetn dropped the cycle after a read grant -> no rvalid, all outputs 0; after release, the first contested cycle grants requester 0.
REQ-035 SHALL cover (MEM_ARB_STATS_EN): 0xFFFF+3 contested cycles -> stat_conflict saturates at 0xFFFF.
REQ-036 SHALL cover: no req for 3 cycles, then both req -> grant goes to the requester not last granted before the idle cycles.
